// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control FSM for the LEGv8-subset core. Sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB), drives the ALU operation and
//   operand select, resolves CBZ from the ALU zero flag, handshakes with the
//   instruction and data memories, traps illegal opcodes and memory timeouts,
//   and counts retired instructions.
//
// Ports
//   clk, rst       core clock, synchronous active-high reset
//   instr          instruction word, valid when imem_ready=1
//   imem_ready     imem read data valid
//   dmem_ready     dmem access complete
//   zero           ALU zero flag (used only in EXEC of CBZ)
//   imem_req       instruction fetch request
//   ir_load        load the datapath instruction register
//   dmem_req       data memory request
//   dmem_we        data memory write enable (qualifies dmem_req)
//   alu_op         AND=0000 ORR=0001 ADD=0010 SUB=0110 CPZ=0111
//   alu_src        0=register B, 1=sign-extended immediate
//   reg_write      register file write strobe
//   mem_to_reg     writeback source: 1=dmem data, 0=ALU result
//   pc_write       PC update strobe (one per retired instruction)
//   pc_src         0=PC+4, 1=branch target
//   illegal        sticky: undecodable opcode trapped
//   bus_err        sticky: memory handshake timeout
//   retire_count   retired instruction count, wraps
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_count
);

  // Wide enough to hold MEM_TIMEOUT itself (MEM_TIMEOUT >= 1).
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_CPZ = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI,
    C_LDUR, C_STUR, C_CBZ, C_B, C_BAD
  } cls_t;

  state_t          state_reg;
  cls_t            cls_reg;
  cls_t            cls_dec;
  logic [10:0]     opcode_reg;
  logic [TO_W-1:0] wait_cnt_reg;
  logic [TO_W-1:0] wait_cnt_next;
  logic            timeout_hit;
  logic            illegal_reg;
  logic            bus_err_reg;
  logic [CNT_W-1:0] retire_count_reg;
  logic [3:0]      exec_op;
  logic            exec_src;
  logic            is_load;
  logic            is_store;
  logic            is_ri;
  logic            unused_instr_bits;

  // Only the opcode field is latched; the operand fields go straight to the
  // datapath instruction register.
  assign unused_instr_bits = ^instr[20:0];

  // Opcode classification. Field widths differ per format, so the shorter
  // opcodes are matched on their prefix only.
  always_comb begin
    cls_dec = C_BAD;
    if      (opcode_reg == 11'b10001011000)       cls_dec = C_ADD;
    else if (opcode_reg == 11'b11001011000)       cls_dec = C_SUB;
    else if (opcode_reg == 11'b10001010000)       cls_dec = C_AND;
    else if (opcode_reg == 11'b10101010000)       cls_dec = C_ORR;
    else if (opcode_reg[10:1] == 10'b1001000100)  cls_dec = C_ADDI;
    else if (opcode_reg[10:1] == 10'b1101000100)  cls_dec = C_SUBI;
    else if (opcode_reg == 11'b11111000010)       cls_dec = C_LDUR;
    else if (opcode_reg == 11'b11111000000)       cls_dec = C_STUR;
    else if (opcode_reg[10:3] == 8'b10110100)     cls_dec = C_CBZ;
    else if (opcode_reg[10:5] == 6'b000101)       cls_dec = C_B;
  end

  // ALU control for the latched class, shared by EXEC and WB.
  always_comb begin
    exec_op  = OP_AND;
    exec_src = 1'b0;
    case (cls_reg)
      C_ADD:          exec_op = OP_ADD;
      C_SUB:          exec_op = OP_SUB;
      C_AND:          exec_op = OP_AND;
      C_ORR:          exec_op = OP_ORR;
      C_ADDI:         begin exec_op = OP_ADD; exec_src = 1'b1; end
      C_SUBI:         begin exec_op = OP_SUB; exec_src = 1'b1; end
      C_LDUR, C_STUR: begin exec_op = OP_ADD; exec_src = 1'b1; end
      C_CBZ:          exec_op = OP_CPZ;
      default:        ;
    endcase
  end

  assign is_load  = (cls_reg == C_LDUR);
  assign is_store = (cls_reg == C_STUR);
  assign is_ri    = (cls_reg == C_ADD) || (cls_reg == C_SUB) ||
                    (cls_reg == C_AND) || (cls_reg == C_ORR) ||
                    (cls_reg == C_ADDI) || (cls_reg == C_SUBI);

  // The wait counter counts ready-low cycles; a timeout fires when this
  // cycle's count would reach MEM_TIMEOUT. Callers qualify with ready low,
  // so a ready arriving on that same cycle still wins.
  assign wait_cnt_next = wait_cnt_reg + TO_W'(1);
  assign timeout_hit   = (wait_cnt_next == TO_W'(MEM_TIMEOUT));

  // Outputs: decoded from state and latched class, qualified by the live
  // ready/zero inputs. Everything is forced low while rst is asserted.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_op     = OP_AND;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        S_EXEC: begin
          alu_op  = exec_op;
          alu_src = exec_src;
          if (cls_reg == C_CBZ) begin
            pc_write = 1'b1;
            pc_src   = zero;
          end else if (cls_reg == C_B) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
        end
        S_MEM: begin
          alu_op   = OP_ADD;
          alu_src  = 1'b1;
          dmem_req = 1'b1;
          dmem_we  = is_store;
          // A store retires on its completion cycle; no WB visit.
          pc_write = is_store && dmem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          pc_write   = 1'b1;
          if (is_ri) begin
            alu_op  = exec_op;
            alu_src = exec_src;
          end
        end
        default: ;
      endcase
    end
  end

  assign illegal      = illegal_reg & ~rst;
  assign bus_err      = bus_err_reg & ~rst;
  assign retire_count = rst ? '0 : retire_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_FETCH;
      cls_reg          <= C_BAD;
      opcode_reg       <= '0;
      wait_cnt_reg     <= '0;
      illegal_reg      <= 1'b0;
      bus_err_reg      <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      // Every retirement is marked by exactly one pc_write cycle.
      if (pc_write) begin
        retire_count_reg <= retire_count_reg + CNT_W'(1);
      end
      case (state_reg)
        S_FETCH: begin
          if (imem_ready) begin
            opcode_reg <= instr[31:21];
            state_reg  <= S_DECODE;
          end else if (timeout_hit) begin
            bus_err_reg <= 1'b1;
            state_reg   <= S_TRAP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        S_DECODE: begin
          cls_reg <= cls_dec;
          if (cls_dec == C_BAD) begin
            illegal_reg <= 1'b1;
            state_reg   <= S_TRAP;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt_reg <= '0;
          case (cls_reg)
            C_LDUR, C_STUR: state_reg <= S_MEM;
            C_CBZ, C_B:     state_reg <= S_FETCH;
            default:        state_reg <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt_reg <= '0;
            state_reg    <= is_store ? S_FETCH : S_WB;
          end else if (timeout_hit) begin
            bus_err_reg <= 1'b1;
            state_reg   <= S_TRAP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        S_WB: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_FETCH;
        end
        S_TRAP: state_reg <= S_TRAP;
        default: state_reg <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// A transaction-level model expands each instruction into the list of
// per-cycle inputs and expected outputs; a hand-written table adds
// independent per-instruction totals, and directed sequences cover reset,
// traps, timeouts and counter wrap.
module tb_multicycle_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4;
  localparam int K_SUBI = 5, K_LDUR = 6, K_STUR = 7, K_CBZ = 8, K_B = 9;
  localparam int K_BAD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             imem_ready, dmem_ready, zero;
  logic             imem_req, ir_load, dmem_req, dmem_we;
  logic [3:0]       alu_op;
  logic             alu_src, reg_write, mem_to_reg, pc_write, pc_src;
  logic             illegal, bus_err;
  logic [CNT_W-1:0] retire_count;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .imem_req(imem_req),
    .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
    .illegal(illegal), .bus_err(bus_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One simulated cycle: inputs to drive and the values expected back.
  // exp = {imem_req, ir_load, dmem_req, dmem_we, alu_op[3:0], alu_src,
  //        reg_write, mem_to_reg, pc_write, pc_src}
  typedef struct {
    logic [31:0]      ins;
    logic             ir;
    logic             dr;
    logic             z;
    logic [12:0]      exp;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    logic             berr;
  } cyc_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          idly;
    int          ddly;
    logic        z;
    int          len;
    int          rw;
    int          dreq;
    int          dwe;
    logic        pcs;
  } vec_t;

  cyc_t             trace[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill, m_berr;
  int               st_len, st_rw, st_dreq, st_dwe;
  logic             st_pcs;
  vec_t             tbl[13];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [12:0] mk(input logic ireq, input logic ild,
      input logic dreq, input logic dwe, input logic [3:0] op,
      input logic src, input logic rw, input logic m2r, input logic pcw,
      input logic pcs);
    return {ireq, ild, dreq, dwe, op, src, rw, m2r, pcw, pcs};
  endfunction

  function automatic logic [12:0] observed();
    return {imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src,
            reg_write, mem_to_reg, pc_write, pc_src};
  endfunction

  function automatic int classify(input logic [31:0] w);
    if (w[31:21] == 11'b10001011000)      return K_ADD;
    if (w[31:21] == 11'b11001011000)      return K_SUB;
    if (w[31:21] == 11'b10001010000)      return K_AND;
    if (w[31:21] == 11'b10101010000)      return K_ORR;
    if (w[31:22] == 10'b1001000100)       return K_ADDI;
    if (w[31:22] == 10'b1101000100)       return K_SUBI;
    if (w[31:21] == 11'b11111000010)      return K_LDUR;
    if (w[31:21] == 11'b11111000000)      return K_STUR;
    if (w[31:24] == 8'b10110100)          return K_CBZ;
    if (w[31:26] == 6'b000101)            return K_B;
    return K_BAD;
  endfunction

  function automatic logic [31:0] gen_instr(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADD:   return {11'b10001011000, r[20:0]};
      K_SUB:   return {11'b11001011000, r[20:0]};
      K_AND:   return {11'b10001010000, r[20:0]};
      K_ORR:   return {11'b10101010000, r[20:0]};
      K_ADDI:  return {10'b1001000100, r[21:0]};
      K_SUBI:  return {10'b1101000100, r[21:0]};
      K_LDUR:  return {11'b11111000010, r[20:0]};
      K_STUR:  return {11'b11111000000, r[20:0]};
      K_CBZ:   return {8'b10110100, r[23:0]};
      default: return {6'b000101, r[25:0]};
    endcase
  endfunction

  // Record one expected cycle; a pc_write cycle retires an instruction.
  task automatic push(input logic [31:0] ins, input logic ir, input logic dr,
                      input logic z, input logic [12:0] e);
    cyc_t c;
    c.ins = ins; c.ir = ir; c.dr = dr; c.z = z; c.exp = e;
    c.cnt = m_cnt; c.ill = m_ill; c.berr = m_berr;
    trace.push_back(c);
    if (e[1]) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic push_tail(input int n);
    for (int i = 0; i < n; i++) push($urandom, rb(), rb(), rb(), 13'd0);
  endtask

  // Expand one instruction into cycles. idly/ddly are ready-low cycles
  // before the memory answers; a delay of MEM_TIMEOUT or more is a timeout.
  task automatic build(input logic [31:0] ins, input int idly, input int ddly,
                       input logic z, input int tail);
    int k;
    logic st;
    logic [3:0] op;
    logic src;
    k = classify(ins);
    for (int i = 0; i < idly && i < MEM_TIMEOUT; i++)
      push($urandom, 1'b0, rb(), rb(),
           mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (idly >= MEM_TIMEOUT) begin
      m_berr = 1'b1;
      push_tail(tail);
      return;
    end
    push(ins, 1'b1, rb(), rb(),
         mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push($urandom, rb(), rb(), rb(), 13'd0);
    if (k == K_BAD) begin
      m_ill = 1'b1;
      push_tail(tail);
      return;
    end
    case (k)
      K_LDUR, K_STUR: begin
        st = (k == K_STUR);
        push($urandom, rb(), rb(), rb(),
             mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < ddly && i < MEM_TIMEOUT; i++)
          push($urandom, rb(), 1'b0, rb(),
               mk(1'b0, 1'b0, 1'b1, st, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        if (ddly >= MEM_TIMEOUT) begin
          m_berr = 1'b1;
          push_tail(tail);
          return;
        end
        push($urandom, rb(), 1'b1, rb(),
             mk(1'b0, 1'b0, 1'b1, st, 4'b0010, 1'b1, 1'b0, 1'b0, st, 1'b0));
        if (!st)
          push($urandom, rb(), rb(), rb(),
               mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      end
      K_CBZ:
        push($urandom, rb(), rb(), z,
             mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, z));
      K_B:
        push($urandom, rb(), rb(), rb(),
             mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      default: begin
        src = (k == K_ADDI) || (k == K_SUBI);
        case (k)
          K_SUB, K_SUBI: op = 4'b0110;
          K_AND:         op = 4'b0000;
          K_ORR:         op = 4'b0001;
          default:       op = 4'b0010;
        endcase
        push($urandom, rb(), rb(), rb(),
             mk(1'b0, 1'b0, 1'b0, 1'b0, op, src, 1'b0, 1'b0, 1'b0, 1'b0));
        push($urandom, rb(), rb(), rb(),
             mk(1'b0, 1'b0, 1'b0, 1'b0, op, src, 1'b1, 1'b0, 1'b1, 1'b0));
      end
    endcase
    push_tail(tail);
  endtask

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic ir, input logic dr,
                      input logic z);
    instr = ins; imem_ready = ir; dmem_ready = dr; zero = z;
    #3;
  endtask

  task automatic check(input string name, input logic ok, input string got,
                       input string want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end else begin
      $display("[TB] pass %s", name);
    end
  endtask

  task automatic run_trace(input string name);
    cyc_t c;
    logic ok;
    logic [12:0] o;
    string got, want;
    ok = 1'b1;
    st_len = 0; st_rw = 0; st_dreq = 0; st_dwe = 0; st_pcs = 1'b0;
    got = "-"; want = "-";
    while (trace.size() > 0) begin
      c = trace.pop_front();
      step(c.ins, c.ir, c.dr, c.z);
      o = observed();
      if (ok && (o !== c.exp || retire_count !== c.cnt ||
                 illegal !== c.ill || bus_err !== c.berr)) begin
        ok = 1'b0;
        got  = $sformatf("cycle %0d out=%b cnt=%0d ill=%b berr=%b",
                         st_len + 1, o, retire_count, illegal, bus_err);
        want = $sformatf("out=%b cnt=%0d ill=%b berr=%b",
                         c.exp, c.cnt, c.ill, c.berr);
      end
      st_len++;
      if (reg_write === 1'b1) st_rw++;
      if (dmem_req === 1'b1) st_dreq++;
      if (dmem_req === 1'b1 && dmem_we === 1'b1) st_dwe++;
      if (pc_write === 1'b1) st_pcs = pc_src;
      next_cycle();
    end
    check(name, ok, got, want);
  endtask

  // Holds rst for n cycles with every input active; all outputs must stay 0.
  task automatic do_reset(input string name, input int n);
    logic ok;
    string got;
    ok = 1'b1;
    got = "-";
    rst = 1'b1;
    m_cnt = '0; m_ill = 1'b0; m_berr = 1'b0;
    trace.delete();
    for (int i = 0; i < n; i++) begin
      step($urandom, 1'b1, 1'b1, 1'b1);
      if (ok && (observed() !== 13'd0 || illegal !== 1'b0 ||
                 bus_err !== 1'b0 || retire_count !== '0)) begin
        ok = 1'b0;
        got = $sformatf("out=%b ill=%b berr=%b cnt=%0d",
                        observed(), illegal, bus_err, retire_count);
      end
      next_cycle();
    end
    rst = 1'b0;
    check(name, ok, got, "all outputs 0");
  endtask

  initial begin
    rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    tbl[0]  = '{"ADD",      32'h8B030041, 0, 0, 1'b0, 4, 1, 0, 0, 1'b0};
    tbl[1]  = '{"SUB_i2",   32'hCB030041, 2, 0, 1'b0, 6, 1, 0, 0, 1'b0};
    tbl[2]  = '{"AND",      32'h8A030041, 0, 0, 1'b0, 4, 1, 0, 0, 1'b0};
    tbl[3]  = '{"ORR_i1",   32'hAA030041, 1, 0, 1'b0, 5, 1, 0, 0, 1'b0};
    tbl[4]  = '{"ADDI",     32'h91000421, 0, 0, 1'b0, 4, 1, 0, 0, 1'b0};
    tbl[5]  = '{"SUBI_i3",  32'hD1000421, 3, 0, 1'b0, 7, 1, 0, 0, 1'b0};
    tbl[6]  = '{"LDUR_d3",  32'hF8400041, 0, 3, 1'b0, 8, 1, 4, 0, 1'b0};
    tbl[7]  = '{"STUR",     32'hF8000041, 0, 0, 1'b0, 4, 0, 1, 1, 1'b0};
    tbl[8]  = '{"CBZ_z1",   32'hB4000041, 0, 0, 1'b1, 3, 0, 0, 0, 1'b1};
    tbl[9]  = '{"CBZ_z0",   32'hB4000041, 0, 0, 1'b0, 3, 0, 0, 0, 1'b0};
    tbl[10] = '{"B",        32'h14000010, 0, 0, 1'b0, 3, 0, 0, 0, 1'b1};
    tbl[11] = '{"STUR_d3",  32'hF8000041, 0, 3, 1'b0, 7, 0, 4, 4, 1'b0};
    tbl[12] = '{"LDUR_i3",  32'hF8400041, 3, 0, 1'b0, 8, 1, 1, 0, 1'b0};

    @(posedge clk);
    #1;
    do_reset("reset_outputs_zero", 3);

    // Table: model-checked trace plus hand-derived per-instruction totals.
    for (int i = 0; i < 13; i++) begin
      build(tbl[i].ins, tbl[i].idly, tbl[i].ddly, tbl[i].z, 0);
      run_trace({tbl[i].name, "_trace"});
      check({tbl[i].name, "_totals"},
            st_len == tbl[i].len && st_rw == tbl[i].rw &&
            st_dreq == tbl[i].dreq && st_dwe == tbl[i].dwe &&
            st_pcs === tbl[i].pcs,
            $sformatf("len=%0d rw=%0d dreq=%0d dwe=%0d pcs=%b",
                      st_len, st_rw, st_dreq, st_dwe, st_pcs),
            $sformatf("len=%0d rw=%0d dreq=%0d dwe=%0d pcs=%b",
                      tbl[i].len, tbl[i].rw, tbl[i].dreq, tbl[i].dwe,
                      tbl[i].pcs));
    end

    // Random legal instructions, random in-budget delays, stray readies.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      build(gen_instr(k), $urandom_range(0, MEM_TIMEOUT - 1),
            $urandom_range(0, MEM_TIMEOUT - 1), rb(), 0);
      run_trace($sformatf("rand%0d_k%0d", i, k));
    end

    // Reset while an LDUR waits in MEM.
    do_reset("reset_before_midmem", 2);
    step(32'hF8400041, 1'b1, 1'b0, 1'b0); next_cycle();
    step($urandom, 1'b0, 1'b0, 1'b0); next_cycle();
    step($urandom, 1'b0, 1'b0, 1'b0); next_cycle();
    step($urandom, 1'b0, 1'b0, 1'b0);
    check("midmem_req_high", dmem_req === 1'b1 && dmem_we === 1'b0,
          $sformatf("dmem_req=%b dmem_we=%b", dmem_req, dmem_we), "1 0");
    next_cycle();
    rst = 1'b1;
    step($urandom, 1'b0, 1'b1, 1'b0);
    check("midmem_rst_drop", dmem_req === 1'b0 && pc_write === 1'b0,
          $sformatf("dmem_req=%b pc_write=%b", dmem_req, pc_write), "0 0");
    next_cycle();
    rst = 1'b0;
    step($urandom, 1'b0, 1'b0, 1'b0);
    check("midmem_restart",
          imem_req === 1'b1 && dmem_req === 1'b0 && retire_count === '0,
          $sformatf("imem_req=%b dmem_req=%b cnt=%0d",
                    imem_req, dmem_req, retire_count), "1 0 0");
    next_cycle();

    // 17 retirements on a 4-bit counter wrap to 1.
    do_reset("reset_before_wrap", 2);
    for (int i = 0; i < 17; i++)
      build(gen_instr(K_B), $urandom_range(0, MEM_TIMEOUT - 1), 0, 1'b0, 0);
    run_trace("b_x17_trace");
    step($urandom, 1'b0, 1'b0, 1'b0);
    check("retire_wrap", retire_count === 4'd1,
          $sformatf("cnt=%0d", retire_count), "cnt=1");
    next_cycle();

    // Illegal opcode: trap for 20 cycles, then reset clears it.
    do_reset("reset_before_illegal", 2);
    build(32'hFFFFFFFF, 0, 0, 1'b0, 20);
    run_trace("illegal_trap_trace");
    do_reset("reset_clears_illegal", 2);
    step($urandom, 1'b0, 1'b0, 1'b0);
    check("fetch_after_illegal_reset", imem_req === 1'b1 && illegal === 1'b0,
          $sformatf("imem_req=%b illegal=%b", imem_req, illegal), "1 0");
    next_cycle();

    // Memory timeouts on each port.
    do_reset("reset_before_itimeout", 2);
    build(32'h8B030041, MEM_TIMEOUT, 0, 1'b0, 6);
    run_trace("imem_timeout_trace");
    do_reset("reset_before_dtimeout", 2);
    build(32'hF8400041, 1, MEM_TIMEOUT, 1'b0, 6);
    run_trace("dmem_timeout_trace");
    do_reset("reset_after_timeout", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the ARM (LEGv8-subset) core; it is the producer side of the ALU interface.
- Sequences fetch/decode/execute/memory/writeback and drives alu_op and alu_src into the ALU.
- Consumes the ALU zero flag to resolve CBZ.
- Handshakes with instruction and data memory, detects illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting on imem_ready/dmem_ready before bus error (≥1).
- CNT_W, 32: width of retire_count.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction word from imem, valid when imem_ready=1
- imem_ready  in  1  imem read data valid
- dmem_ready  in  1  dmem access complete
- zero  in  1  ALU zero flag
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register (datapath)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (valid with dmem_req)
- alu_op  out  4  AND=0000, ORR=0001, ADD=0010, SUB=0110, CPZ=0111
- alu_src  out  1  0=register B operand, 1=sign-extended immediate
- reg_write  out  1  register file write strobe
- mem_to_reg  out  1  writeback source: 1=dmem data, 0=ALU result
- pc_write  out  1  PC update strobe
- pc_src  out  1  0=PC+4, 1=branch target
- illegal  out  1  sticky: undecodable opcode trapped
- bus_err  out  1  sticky: memory handshake timeout
- retire_count  out  CNT_W  retired instruction count, wraps

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk.
  - rst=1 forces state FETCH, opcode latch 0, timeout counter 0, illegal=0, bus_err=0, retire_count=0.
  - While rst=1, every output is 0.
- Output timing: outputs are combinational from state, the latched class and the ready/zero inputs (Moore plus ready qualification). Outputs not listed for a state are 0; alu_op defaults to 0000.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_load=1 for that cycle; instr[31:21] latched internally; go to DECODE.
- DECODE: classify the latched opcode:
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - ADDI [31:22]=1001000100
  - SUBI [31:22]=1101000100
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ [31:24]=10110100
  - B [31:26]=000101
  - Any match goes to EXEC. No match sets illegal=1 and goes to TRAP.
- EXEC:
  - R-type: alu_src=0, alu_op per the instruction; go to WB.
  - ADDI/SUBI: alu_src=1, alu_op ADD/SUB; go to WB.
  - LDUR/STUR: alu_src=1, alu_op=ADD; go to MEM.
  - CBZ: alu_op=CPZ, alu_src=0, pc_write=1, pc_src=zero; retire; go to FETCH.
  - B: pc_write=1, pc_src=1; retire; go to FETCH.
- MEM:
  - alu_op=ADD, alu_src=1 held; dmem_req=1; dmem_we=1 for STUR.
  - On dmem_ready, LDUR goes to WB.
  - On dmem_ready, STUR drives pc_write=1, pc_src=0 in the same cycle, retires, and goes to FETCH.
- WB:
  - reg_write=1, mem_to_reg=1 for LDUR only, pc_write=1, pc_src=0.
  - Retires; goes to FETCH.
  - alu_op and alu_src hold their EXEC values in WB for R/I-types.
- Retirement: retire_count increments by 1 in the cycle that pc_write=1. It wraps from 2^CNT_W-1 to 0.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle the relevant ready is low.
  - If the counter reaches MEM_TIMEOUT with ready still low: bus_err=1, go to TRAP, drop the request next cycle.
  - A ready arriving in the same cycle the counter hits MEM_TIMEOUT wins: normal progress, no error.
- TRAP: all strobes 0; stays in TRAP until rst. illegal and bus_err stay set.
- Minimum latencies (ready asserted immediately):
  - CBZ/B: 3 cycles
  - R/I-type and STUR: 4 cycles
  - LDUR: 5 cycles
- Stray inputs: ready inputs seen outside their waiting state are ignored. zero is sampled only in EXEC for CBZ.
- Reset mid-operation: rst during MEM drops dmem_req in the rst cycle; no pc_write; restart at FETCH.

Test Plan:
- ADD X1,X2,X3 (instr=0x8B030041), ready immediate -> ir_load cycle 1; alu_op=0010, alu_src=0 in EXEC; reg_write=1, pc_write=1, pc_src=0 in cycle 4; retire_count=1.
- LDUR with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has mem_to_reg=1 and reg_write=1; total 8 cycles.
- CBZ twice, zero=1 then zero=0 -> EXEC alu_op=0111 both times; pc_src=1 then 0; pc_write=1 each; no reg_write.
- STUR then B -> STUR: dmem_we=1 and pc_write on the dmem_ready cycle, no reg_write. B: pc_src=1 in cycle 3. retire_count=2.
- instr=0xFFFFFFFF -> illegal=1 in DECODE+1, TRAP; imem_req stays 0 for 20 cycles; rst clears illegal, and imem_req=1 on the cycle after rst deasserts.
- imem_ready held 0, MEM_TIMEOUT=4 -> bus_err=1 after 4 wait cycles, then TRAP. Separately: preload retire_count near 2^CNT_W-1 using CNT_W=4 and 17 retires -> count wraps to 1.
